// File: rtl/sseg_scanner.sv
// Multiplexed N-digit seven-segment scanner with refresh prescaler, PWM brightness
// and a double-buffered digit frame that is swapped only on a frame wrap.
module sseg_scanner #(
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned DIV            = 20,
    parameter int unsigned BRIGHT_W       = 3,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned SEL_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_pos,
    input  logic [4:0]                wr_digit,
    input  logic                      wr_dp,
    input  logic                      commit,
    output logic                      commit_pending,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [7:0]                digit_segs,
    output logic [DIGITS-1:0]         digit_sel,
    output logic                      frame_done
);

    localparam int unsigned POS_W = $clog2(DIGITS);
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0]    PRE_MAX   = PRE_W'(DIV - 1);
    localparam logic [POS_W-1:0]    POS_MAX   = POS_W'(DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] PHASE_MAX = {BRIGHT_W{1'b1}};
    localparam logic [7:0]          SEGS_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0]   SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                      : {DIGITS{1'b0}};

    typedef struct packed {
        logic       blank;
        logic [3:0] value;
        logic       dp;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{blank: 1'b1, value: 4'h0, dp: 1'b0};

    // Hex value to active-high segment code, bit0=a .. bit6=g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]    pre_q,   pre_d;
    logic [BRIGHT_W-1:0] phase_q, phase_d;
    logic [POS_W-1:0]    pos_q,   pos_d;
    digit_t              shadow_q [DIGITS];
    digit_t              shadow_d [DIGITS];
    digit_t              active_q [DIGITS];
    digit_t              active_d [DIGITS];
    logic                pending_d;
    logic                frame_done_d;
    logic [7:0]          segs_d;
    logic [DIGITS-1:0]   sel_d;

    logic                tick_c;
    logic                wrap_c;
    logic                transfer_c;
    digit_t              cur_c;
    logic [DIGITS-1:0]   sel_raw_c;

    // Next-state: prescaler, scan counters, frame buffers, handshake and output stage.
    always_comb begin
        pre_d        = pre_q + PRE_W'(1);
        phase_d      = phase_q;
        pos_d        = pos_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = commit_pending;
        tick_c       = 1'b0;
        wrap_c       = 1'b0;
        transfer_c   = 1'b0;
        cur_c        = active_q[pos_q];
        sel_raw_c    = '0;
        frame_done_d = 1'b0;
        segs_d       = SEGS_OFF;
        sel_d        = SEL_OFF;

        tick_c = (pre_q == PRE_MAX);
        wrap_c = tick_c && (phase_q == PHASE_MAX) && (pos_q == POS_MAX);

        if (tick_c) begin
            pre_d   = '0;
            phase_d = phase_q + BRIGHT_W'(1);
            if (phase_q == PHASE_MAX) begin
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
            end
        end

        // A commit arriving while already pending (including on the wrap) changes nothing.
        transfer_c = wrap_c && commit_pending;
        if (transfer_c) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end

        // Transfer reads shadow_q, so a coincident write is not copied.
        if (transfer_c) begin
            active_d = shadow_q;
        end
        if (wr_en && (32'(wr_pos) < DIGITS)) begin
            shadow_d[wr_pos] = '{blank: wr_digit[4], value: wr_digit[3:0], dp: wr_dp};
        end

        frame_done_d = wrap_c;

        if (phase_q <= brightness) begin
            sel_raw_c[pos_q] = 1'b1;
        end
        segs_d = {cur_c.dp, cur_c.blank ? 7'h00 : hex_to_seg(cur_c.value)} ^ SEGS_OFF;
        sel_d  = sel_raw_c ^ SEL_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q          <= '0;
            phase_q        <= '0;
            pos_q          <= '0;
            commit_pending <= 1'b0;
            frame_done     <= 1'b0;
            digit_segs     <= SEGS_OFF;
            digit_sel      <= SEL_OFF;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= DIGIT_BLANK;
                active_q[i] <= DIGIT_BLANK;
            end
        end else begin
            pre_q          <= pre_d;
            phase_q        <= phase_d;
            pos_q          <= pos_d;
            commit_pending <= pending_d;
            frame_done     <= frame_done_d;
            digit_segs     <= segs_d;
            digit_sel      <= sel_d;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sseg_scanner.sv
// Directed bench for sseg_scanner: a small active-high build for scan, brightness and
// commit behaviour, plus a default-polarity build for reset and out-of-range writes.
module tb_sseg_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_en;
    logic [1:0] wr_pos;
    logic [4:0] wr_digit;
    logic       wr_dp;
    logic       commit;
    logic [1:0] brightness;
    logic       pending;
    logic [7:0] segs;
    logic [3:0] sel;
    logic       fd;

    logic       a_wr_en;
    logic [2:0] a_wr_pos;
    logic [4:0] a_wr_digit;
    logic       a_wr_dp;
    logic       a_commit;
    logic [0:0] a_brightness;
    logic       a_pending;
    logic [7:0] a_segs;
    logic [5:0] a_sel;
    logic       a_fd;

    int checks   = 0;
    int failures = 0;

    sseg_scanner #(
        .DIGITS(4), .DIV(2), .BRIGHT_W(2), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_pos(wr_pos), .wr_digit(wr_digit),
        .wr_dp(wr_dp), .commit(commit), .commit_pending(pending), .brightness(brightness),
        .digit_segs(segs), .digit_sel(sel), .frame_done(fd)
    );

    sseg_scanner #(
        .DIGITS(6), .DIV(1), .BRIGHT_W(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) u_alt (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_pos(a_wr_pos), .wr_digit(a_wr_digit),
        .wr_dp(a_wr_dp), .commit(a_commit), .commit_pending(a_pending),
        .brightness(a_brightness), .digit_segs(a_segs), .digit_sel(a_sel), .frame_done(a_fd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_digit(input logic [1:0] pos, input logic [4:0] dig, input logic dp);
        wr_en    = 1'b1;
        wr_pos   = pos;
        wr_digit = dig;
        wr_dp    = dp;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // Returns on the negedge of the cycle where frame_done is high.
    task automatic wait_fd(input string tag, input bit chk, input logic [7:0] seg_exp,
                           input logic pend_exp);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (fd) begin
                seen = 1'b1;
            end else if (chk) begin
                check({tag, "_old_segs"}, 32'(segs), 32'(seg_exp));
                check({tag, "_pend"}, 32'(pending), 32'(pend_exp));
            end
        end
        check({tag, "_fd_seen"}, 32'(seen), 32'd1);
    endtask

    // Checks one full frame starting just after a frame_done negedge; optional action at cycle act_c.
    task automatic scan_frame(input string tag, input logic [1:0] bright,
                              input logic [31:0] exp_segs, input int act_c,
                              input bit act_commit, input bit act_wr,
                              input logic [1:0] act_pos, input logic [4:0] act_digit);
        int         i;
        int         p;
        int         ph;
        logic [3:0] sel_exp;
        brightness = bright;
        if (act_c == 0) begin
            commit = act_commit; wr_en = act_wr; wr_pos = act_pos; wr_digit = act_digit; wr_dp = 1'b0;
        end
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            commit = 1'b0;
            wr_en  = 1'b0;
            i  = c - 1;
            p  = i / 8;
            ph = (i / 2) % 4;
            sel_exp = (ph <= int'(bright)) ? 4'(1 << p) : 4'h0;
            check({tag, "_sel"}, 32'(sel), 32'(sel_exp));
            check({tag, "_segs"}, 32'(segs), 32'(exp_segs[8*p +: 8]));
            check({tag, "_fd"}, 32'(fd), (c == 32) ? 32'd1 : 32'd0);
            if (c == act_c) begin
                commit = act_commit; wr_en = act_wr; wr_pos = act_pos; wr_digit = act_digit; wr_dp = 1'b0;
            end
        end
    endtask

    initial begin
        int fds;
        rst = 1'b1;
        wr_en = 1'b0; wr_pos = '0; wr_digit = '0; wr_dp = 1'b0; commit = 1'b0;
        brightness = 2'd3;
        a_wr_en = 1'b0; a_wr_pos = '0; a_wr_digit = '0; a_wr_dp = 1'b0; a_commit = 1'b0;
        a_brightness = 1'b1;

        // Reset state of both builds.
        repeat (3) begin
            @(negedge clk);
            check("rst_a_segs", 32'(a_segs), 32'hFF);
            check("rst_a_sel", 32'(a_sel), 32'h3F);
            check("rst_a_pend", 32'(a_pending), 32'd0);
            check("rst_segs", 32'(segs), 32'h00);
            check("rst_sel", 32'(sel), 32'h0);
            check("rst_pend", 32'(pending), 32'd0);
            check("rst_fd", 32'(fd), 32'd0);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("blank_a_segs", 32'(a_segs), 32'hFF);
        end

        // Out-of-range writes on the 6-digit build must not alter the frame.
        a_wr_en = 1'b1; a_wr_pos = 3'd6; a_wr_digit = 5'h08; a_wr_dp = 1'b1;
        @(negedge clk);
        a_wr_pos = 3'd7;
        @(negedge clk);
        a_wr_en = 1'b0;
        a_commit = 1'b1;
        @(negedge clk);
        a_commit = 1'b0;
        fds = 0;
        for (int n = 0; n < 40 && fds < 2; n++) begin
            @(negedge clk);
            if (a_fd) fds++;
        end
        check("oor_fd_seen", 32'(fds), 32'd2);
        repeat (12) begin
            @(negedge clk);
            check("oor_a_segs", 32'(a_segs), 32'hFF);
            check("oor_a_pend", 32'(a_pending), 32'd0);
        end

        // Scan timing and brightness on the blank frame.
        wait_fd("sync", 1'b0, 8'h00, 1'b0);
        scan_frame("b3", 2'd3, 32'h0, -1, 1'b0, 1'b0, 2'd0, 5'h0);
        scan_frame("b0", 2'd0, 32'h0, -1, 1'b0, 1'b0, 2'd0, 5'h0);
        scan_frame("b1", 2'd1, 32'h0, -1, 1'b0, 1'b0, 2'd0, 5'h0);

        // Mid-frame commit: old frame held until the wrap.
        brightness = 2'd3;
        write_digit(2'd0, 5'h01, 1'b0);
        write_digit(2'd1, 5'h02, 1'b1);
        write_digit(2'd2, 5'h03, 1'b0);
        write_digit(2'd3, 5'h04, 1'b0);
        commit_pulse();
        check("commit_pend_set", 32'(pending), 32'd1);
        wait_fd("commit", 1'b1, 8'h00, 1'b1);
        check("commit_pend_clr", 32'(pending), 32'd0);
        check("commit_wrap_segs", 32'(segs), 32'h00);
        scan_frame("f1", 2'd3, 32'h664FDB06, 10, 1'b0, 1'b1, 2'd0, 5'h05);
        // Commit on the wrap cycle: pending, not transferred yet.
        scan_frame("f2", 2'd3, 32'h664FDB06, 31, 1'b1, 1'b0, 2'd0, 5'h00);
        check("wrap_commit_pend", 32'(pending), 32'd1);
        // Write coincident with the transfer: pre-write value goes active.
        scan_frame("f3", 2'd3, 32'h664FDB06, 31, 1'b0, 1'b1, 2'd0, 5'h07);
        check("xfer_pend_clr", 32'(pending), 32'd0);
        scan_frame("f4", 2'd3, 32'h664FDB6D, 0, 1'b1, 1'b0, 2'd0, 5'h00);
        scan_frame("f5", 2'd3, 32'h664FDB07, -1, 1'b0, 1'b0, 2'd0, 5'h00);

        // Remaining letters and blank-with-dp.
        write_digit(2'd0, 5'h0A, 1'b0);
        write_digit(2'd1, 5'h0B, 1'b0);
        write_digit(2'd2, 5'h0F, 1'b0);
        write_digit(2'd3, 5'h10, 1'b1);
        commit_pulse();
        wait_fd("hex", 1'b0, 8'h00, 1'b0);
        scan_frame("f6", 2'd3, 32'h80717C77, -1, 1'b0, 1'b0, 2'd0, 5'h00);

        // Reset mid-frame with a commit pending.
        write_digit(2'd1, 5'h09, 1'b0);
        commit_pulse();
        check("mid_pend_set", 32'(pending), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_segs", 32'(segs), 32'h00);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_pend", 32'(pending), 32'd0);
        check("mid_rst_fd", 32'(fd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_fd("post_rst", 1'b1, 8'h00, 1'b0);
        scan_frame("post_rst", 2'd3, 32'h0, -1, 1'b0, 1'b0, 2'd0, 5'h00);
        scan_frame("post_rst2", 2'd3, 32'h0, -1, 1'b0, 1'b0, 2'd0, 5'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
